// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Holds the MEM/WB register, picks ALU
// result or load data, drives the register-file write port, and stalls the
// pipeline while a load waits for variable-latency memory data. A watchdog
// drops a load that never gets its data so the pipeline cannot hang.
// Optional build macro: WB_INSTRET_EN (retired-instruction counter).

module writeback_stage #(
    parameter int LOAD_TIMEOUT = 15,  // max WAIT cycles before a load is dropped (1..255)
    parameter int CNT_W        = 8    // wait counter width, must hold LOAD_TIMEOUT
) (
    input  logic        clk,
    input  logic        clrn,         // asynchronous, active-high clear
    input  logic        mem_valid,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    input  logic [31:0] mem_alu,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wdi,
    output logic [4:0]  wb_rd,
    output logic        wb_wreg,
    output logic        wb_stall,
    output logic        wb_err,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } wb_state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LOAD_TIMEOUT);

    // MEM/WB pipeline entry
    logic        v;
    logic        wreg;
    logic        m2reg;
    logic [4:0]  rn;
    logic [31:0] alu;

    wb_state_t        state;
    wb_state_t        state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             capture;

    // A load is dropped when it has waited LOAD_TIMEOUT cycles and data still
    // has not arrived; this releases the stall in the same cycle.
    assign timeout  = (state == ST_WAIT) && !dmem_rvalid && (wait_cnt == TIMEOUT_CNT);
    assign wb_stall = v & m2reg & ~dmem_rvalid & ~timeout;
    assign capture  = ~wb_stall;

    // Write port: a timed-out load never writes because dmem_rvalid is low.
    assign wdi     = m2reg ? dmem_rdata : alu;
    assign wb_rd   = rn;
    assign wb_wreg = v & wreg & (rn != 5'd0) & (~m2reg | dmem_rvalid);

    // Pipeline register: take the MEM instruction whenever WB is not stalled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            v     <= 1'b0;
            wreg  <= 1'b0;
            m2reg <= 1'b0;
            rn    <= 5'd0;
            alu   <= 32'd0;
        end else if (capture) begin
            v     <= mem_valid;
            wreg  <= mem_wreg;
            m2reg <= mem_m2reg;
            rn    <= mem_rn;
            alu   <= mem_alu;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) state <= ST_EMPTY;
        else      state <= state_next;
    end

    // Next state: re-derived from the incoming instruction on every capture;
    // a stalled entry stays in WAIT.
    // NOTE: state_next is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (capture) begin
            if (!mem_valid)     state_next = ST_EMPTY;
            else if (mem_m2reg) state_next = ST_WAIT;
            else                state_next = ST_ACTIVE;
        end
    end

    // Wait counter: cleared on capture, counts empty WAIT cycles, saturates.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wait_cnt <= '0;
        end else if (capture) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT && !dmem_rvalid && wait_cnt != TIMEOUT_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky error flag: set by any load timeout, cleared only by reset.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn)         wb_err <= 1'b0;
        else if (timeout) wb_err <= 1'b1;
    end

`ifdef WB_INSTRET_EN
    // Retired-instruction counter: any valid entry leaving WB, wraps at 2^32.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn)               instret <= 32'd0;
        else if (v && !wb_stall) instret <= instret + 32'd1;
    end
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.

module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mem_valid, mem_wreg, mem_m2reg;
    logic [4:0]  mem_rn;
    logic [31:0] mem_alu;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] wdi;
    logic [4:0]  wb_rd;
    logic        wb_wreg, wb_stall, wb_err;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;  // retire events since last reset

`ifdef WB_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    writeback_stage #(.LOAD_TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .clrn(clrn),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_rn(mem_rn), .mem_alu(mem_alu),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wdi(wdi), .wb_rd(wb_rd), .wb_wreg(wb_wreg), .wb_stall(wb_stall),
        .wb_err(wb_err), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic val, input logic wr, input logic ld,
                           input logic [4:0] rn, input logic [31:0] alu);
        mem_valid = val; mem_wreg = wr; mem_m2reg = ld; mem_rn = rn; mem_alu = alu;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #3;
        n_checks++; if (wb_wreg !== 1'b0)   begin n_fail++; $display("FAIL reset_wreg: got %b want 0", wb_wreg); end
        n_checks++; if (wb_stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %b want 0", wb_stall); end
        n_checks++; if (wdi !== 32'd0)      begin n_fail++; $display("FAIL reset_wdi: got %h want 0", wdi); end
        n_checks++; if (wb_rd !== 5'd0)     begin n_fail++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
        n_checks++; if (wb_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_err); end
        n_checks++; if (instret !== 32'd0)  begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
        #5 clrn = 1'b0;   // t=8, clear of the t=15 edge
        exp_ret = 0;
    endtask

    task automatic test_alu_writeback();
        tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1234);
        tick();
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        // Stray load data while an ALU op is in WB must be ignored.
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b1)        begin n_fail++; $display("FAIL alu_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_rd !== 5'd5)          begin n_fail++; $display("FAIL alu_rd: got %0d want 5", wb_rd); end
        n_checks++; if (wdi !== 32'h0000_1234)   begin n_fail++; $display("FAIL alu_wdi: got %h want 00001234", wdi); end
        n_checks++; if (wb_stall !== 1'b0)       begin n_fail++; $display("FAIL alu_stall: got %b want 0", wb_stall); end
        exp_ret++;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b0)        begin n_fail++; $display("FAIL alu_empty_wreg: got %b want 0", wb_wreg); end
        n_checks++; if (instret !== (INSTRET_ON ? 32'(exp_ret) : 32'd0))
            begin n_fail++; $display("FAIL alu_instret: got %0d want %0d", instret, INSTRET_ON ? exp_ret : 0); end
    endtask

    task automatic test_load_latency();
        tick();
        set_mem(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0100);
        tick();  // WB cycle 1 of the load; next MEM instruction presented and held
        set_mem(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_AAAA);
        @(negedge clk);
        n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c1: got %b want 1", wb_stall); end
        n_checks++; if (wb_wreg !== 1'b0)  begin n_fail++; $display("FAIL ld_wreg_c1: got %b want 0", wb_wreg); end
        tick();  // WB cycle 2
        @(negedge clk);
        n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c2: got %b want 1", wb_stall); end
        n_checks++; if (wb_rd !== 5'd7)    begin n_fail++; $display("FAIL ld_rd_c2: got %0d want 7", wb_rd); end
        tick();  // WB cycle 3: data arrives
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (wb_stall !== 1'b0)       begin n_fail++; $display("FAIL ld_stall_c3: got %b want 0", wb_stall); end
        n_checks++; if (wb_wreg !== 1'b1)        begin n_fail++; $display("FAIL ld_wreg_c3: got %b want 1", wb_wreg); end
        n_checks++; if (wdi !== 32'hDEAD_BEEF)   begin n_fail++; $display("FAIL ld_wdi_c3: got %h want deadbeef", wdi); end
        n_checks++; if (wb_rd !== 5'd7)          begin n_fail++; $display("FAIL ld_rd_c3: got %0d want 7", wb_rd); end
        exp_ret++;
        tick();  // the held ALU instruction is now in WB
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b1)       begin n_fail++; $display("FAIL ld_next_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_rd !== 5'd9)         begin n_fail++; $display("FAIL ld_next_rd: got %0d want 9", wb_rd); end
        n_checks++; if (wdi !== 32'h0000_AAAA)  begin n_fail++; $display("FAIL ld_next_wdi: got %h want 0000aaaa", wdi); end
        exp_ret++;
    endtask

    task automatic test_r0_suppress();
        tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_FFFF);
        tick();
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b0)       begin n_fail++; $display("FAIL r0_wreg: got %b want 0", wb_wreg); end
        n_checks++; if (wdi !== 32'h0000_FFFF)  begin n_fail++; $display("FAIL r0_wdi: got %h want 0000ffff", wdi); end
        exp_ret++;
        tick();
        @(negedge clk);
        n_checks++; if (instret !== (INSTRET_ON ? 32'(exp_ret) : 32'd0))
            begin n_fail++; $display("FAIL r0_instret: got %0d want %0d", instret, INSTRET_ON ? exp_ret : 0); end
    endtask

    task automatic test_timeout();
        int stall_cycles;
        tick();
        set_mem(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0040);
        tick();  // load WB cycle 1; follower held in MEM
        set_mem(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0055);
        stall_cycles = 0;
        @(negedge clk);
        if (wb_stall === 1'b1 && wb_wreg === 1'b0) stall_cycles++;
        for (int i = 2; i <= 15; i++) begin
            tick();
            @(negedge clk);
            if (wb_stall === 1'b1 && wb_wreg === 1'b0) stall_cycles++;
        end
        n_checks++; if (stall_cycles != 15) begin n_fail++; $display("FAIL to_stall_cycles: got %0d want 15", stall_cycles); end
        tick();  // cycle 16: timeout, entry retires without a write
        @(negedge clk);
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL to_release_stall: got %b want 0", wb_stall); end
        n_checks++; if (wb_wreg !== 1'b0)  begin n_fail++; $display("FAIL to_release_wreg: got %b want 0", wb_wreg); end
        exp_ret++;
        tick();  // follower ALU op writes normally
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (wb_err !== 1'b1)        begin n_fail++; $display("FAIL to_err_set: got %b want 1", wb_err); end
        n_checks++; if (wb_wreg !== 1'b1)       begin n_fail++; $display("FAIL to_next_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_rd !== 5'd4)         begin n_fail++; $display("FAIL to_next_rd: got %0d want 4", wb_rd); end
        n_checks++; if (wdi !== 32'h0000_0055)  begin n_fail++; $display("FAIL to_next_wdi: got %h want 00000055", wdi); end
        exp_ret++;
        tick();
        @(negedge clk);
        n_checks++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", wb_err); end
        n_checks++; if (instret !== (INSTRET_ON ? 32'(exp_ret) : 32'd0))
            begin n_fail++; $display("FAIL to_instret: got %0d want %0d", instret, INSTRET_ON ? exp_ret : 0); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        set_mem(1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0080);
        tick();
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL rmw_pre_stall: got %b want 1", wb_stall); end
        #1 clrn = 1'b1;
        #1;
        n_checks++; if (wb_stall !== 1'b0)  begin n_fail++; $display("FAIL rmw_stall: got %b want 0", wb_stall); end
        n_checks++; if (wb_wreg !== 1'b0)   begin n_fail++; $display("FAIL rmw_wreg: got %b want 0", wb_wreg); end
        n_checks++; if (wb_err !== 1'b0)    begin n_fail++; $display("FAIL rmw_err: got %b want 0", wb_err); end
        n_checks++; if (instret !== 32'd0)  begin n_fail++; $display("FAIL rmw_instret: got %0d want 0", instret); end
        #1 clrn = 1'b0;
        exp_ret = 0;
        tick();
        set_mem(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0077);
        tick();
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b1)       begin n_fail++; $display("FAIL rmw_after_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_rd !== 5'd8)         begin n_fail++; $display("FAIL rmw_after_rd: got %0d want 8", wb_rd); end
        n_checks++; if (wdi !== 32'h0000_0077)  begin n_fail++; $display("FAIL rmw_after_wdi: got %h want 00000077", wdi); end
        exp_ret++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [3];
        data[0] = 32'h1111_1111; data[1] = 32'h2222_2222; data[2] = 32'h3333_3333;
        @(negedge clk);
        #1 clrn = 1'b1;
        #2 clrn = 1'b0;
        exp_ret = 0;
        tick();
        set_mem(1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_rvalid = 1'b1; dmem_rdata = data[i];
            if (i < 2) set_mem(1'b1, 1'b1, 1'b1, 5'(i + 2), 32'h0000_0010 + 32'(i + 1));
            else       set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            n_checks++; if (wb_stall !== 1'b0 || wb_wreg !== 1'b1 || wb_rd !== 5'(i + 1) || wdi !== data[i])
                begin n_fail++; $display("FAIL b2b_load%0d: got stall=%b wreg=%b rd=%0d wdi=%h want stall=0 wreg=1 rd=%0d wdi=%h",
                                         i, wb_stall, wb_wreg, wb_rd, wdi, i + 1, data[i]); end
            exp_ret++;
        end
        tick();  // WB empty; stray rvalid must not write
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0044;
        @(negedge clk);
        n_checks++; if (wb_wreg !== 1'b0 || wb_stall !== 1'b0)
            begin n_fail++; $display("FAIL b2b_empty: got wreg=%b stall=%b want 0 0", wb_wreg, wb_stall); end
        n_checks++; if (instret !== (INSTRET_ON ? 32'd3 : 32'd0))
            begin n_fail++; $display("FAIL b2b_instret: got %0d want %0d", instret, INSTRET_ON ? 3 : 0); end
        n_checks++; if (exp_ret != 3)
            begin n_fail++; $display("FAIL b2b_retire_count: got %0d want 3", exp_ret); end
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_load_latency();
        test_r0_suppress();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
